fetch_queue: RTL and testbench

- Parametrised instruction-prefetch stage that replaces the single-entry fetch between instruction memory and decode.
- Keeps up to DEPTH fetched instructions, each tagged with its PC, in a FIFO. Presents the head entry to decode through a valid/ready handshake.
- On a taken jump from mem_branch it flushes the queue, drops any in-flight fetch, redirects to the jump target and raises pipe_flush.
- Detects misaligned jump targets and halts fetch with a sticky fault.

---
 rtl/fetch_queue_if.sv | 17 +
 rtl/fetch_queue.sv | 113 +++++++++++
 tb/tb_fetch_queue.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Branch-redirect and decode-handshake bundles used by the fetch queue.
// The master side drives the request/data; the slave side consumes it.
interface fq_branch_if #(parameter int XLEN = 32);
  logic            jump_taken;
  logic [XLEN-1:0] jump_target;
  modport master (output jump_taken, jump_target);
  modport slave  (input  jump_taken, jump_target);
endinterface

interface fq_decode_if #(parameter int XLEN = 32);
  logic            valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ins;
  logic            ready;
  modport master (output valid, pc, ins, input  ready);
  modport slave  (input  valid, pc, ins, output ready);
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: keeps up to DEPTH {pc, ins} entries ahead of decode,
// flushes and redirects on taken jumps, and halts on a misaligned target.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int             CW       = $clog2(DEPTH+1)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  fq_branch_if.slave      mb_if,
  fq_decode_if.master     if_id,
  output logic            pipe_flush,
  output logic [CW-1:0]   occupancy,
  output logic            fault
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW1 = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pend_q, pend_d, fault_q, fault_d;
  logic [XLEN-1:0] mem_pc_q  [DEPTH];
  logic [XLEN-1:0] mem_ins_q [DEPTH];

  logic            flush, aligned, valid, pop, push, req;
  logic [CW1-1:0]  in_use;

  always_comb begin
    flush   = mb_if.jump_taken;
    aligned = (mb_if.jump_target[1:0] == 2'b00);
    valid   = (count_q != '0);
    pop     = valid & if_id.ready & ~flush;
    push    = pend_q & ~flush;
    // Entries held plus the one in flight, minus the one leaving this cycle.
    in_use  = CW1'(count_q) + CW1'(pend_q) - CW1'(pop);

    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    count_d   = count_q;
    pend_d    = 1'b0;
    fault_d   = fault_q;
    req       = 1'b0;
    imem_addr = pc_q;

    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      if (!fault_q && aligned) begin
        req       = 1'b1;
        imem_addr = mb_if.jump_target;
        req_pc_d  = mb_if.jump_target;
        pc_d      = mb_if.jump_target + XLEN'(4);
        pend_d    = 1'b1;
      end else if (!fault_q) begin
        fault_d = 1'b1;
      end
    end else begin
      req = ~fault_q & (in_use < CW1'(DEPTH));
      if (req) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + XLEN'(4);
      end
      pend_d  = req;
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    imem_req   = req & ~reset;
    pipe_flush = mb_if.jump_taken & ~reset;
    occupancy  = count_q;
    fault      = fault_q;
    if_id.valid = valid;
    if_id.pc    = valid ? mem_pc_q[rd_q]  : '1;
    if_id.ins   = valid ? mem_ins_q[rd_q] : XLEN'(32'h0000_0013);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      fault_q  <= fault_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_pc_q[wr_q]  <= req_pc_q;
      mem_ins_q[wr_q] <= imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, flush, fault and pc wrap.
module tb_fetch_queue;
  localparam int XLEN = 32, DEPTH = 4, CW = $clog2(DEPTH+1);

  logic            clk = 1'b0, reset = 1'b1;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr, imem_rdata = '0;
  logic            pipe_flush, fault;
  logic [CW-1:0]   occupancy;
  int              total = 0, bad = 0;

  fq_branch_if #(.XLEN(XLEN)) mb();
  fq_decode_if #(.XLEN(XLEN)) dec();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .mb_if(mb), .if_id(dec), .pipe_flush(pipe_flush),
    .occupancy(occupancy), .fault(fault));

  always #5 clk = ~clk;
  // Instruction memory: returns addr ^ 0x13 one cycle after the request.
  always @(posedge clk) imem_rdata <= imem_addr ^ 32'h13;

  task automatic tick; @(posedge clk); #1; endtask

  task automatic do_reset;
    reset = 1'b1; mb.jump_taken = 1'b0; mb.jump_target = '0; dec.ready = 1'b0;
    tick; tick; reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; mb.jump_taken = 1'b1; mb.jump_target = 32'h40; dec.ready = 1'b1;
    tick; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    total++; if (pipe_flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b exp=0", pipe_flush); end
    total++; if (dec.valid !== 1'b0 || occupancy !== 0 || fault !== 1'b0)
      begin bad++; $display("FAIL rst_state valid=%b occ=%0d fault=%b exp=0/0/0", dec.valid, occupancy, fault); end
    total++; if (dec.pc !== 32'hffffffff || dec.ins !== 32'h13)
      begin bad++; $display("FAIL rst_head pc=%h ins=%h exp=ffffffff/00000013", dec.pc, dec.ins); end
    mb.jump_taken = 1'b0;
    tick; reset = 1'b0;
  endtask

  task automatic test_stream;
    do_reset; dec.ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*c))
        begin bad++; $display("FAIL stream_req c=%0d req=%b addr=%h exp=1/%h", c, imem_req, imem_addr, 32'(4*c)); end
      if (c < 2) begin
        total++; if (dec.valid !== 1'b0 || dec.pc !== 32'hffffffff || dec.ins !== 32'h13)
          begin bad++; $display("FAIL stream_empty c=%0d valid=%b pc=%h ins=%h", c, dec.valid, dec.pc, dec.ins); end
      end else begin
        total++; if (dec.valid !== 1'b1 || dec.pc !== 32'(4*(c-2)) || dec.ins !== (32'(4*(c-2)) ^ 32'h13))
          begin bad++; $display("FAIL stream_head c=%0d valid=%b pc=%h ins=%h exp_pc=%h", c, dec.valid, dec.pc, dec.ins, 32'(4*(c-2))); end
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    int nreq;
    do_reset; nreq = 0;
    for (int c = 0; c < 8; c++) begin #1; if (imem_req) nreq++; tick; end
    #1;
    total++; if (nreq != 4) begin bad++; $display("FAIL bp_nreq got=%0d exp=4", nreq); end
    total++; if (occupancy !== 4 || imem_req !== 1'b0)
      begin bad++; $display("FAIL bp_full occ=%0d req=%b exp=4/0", occupancy, imem_req); end
    dec.ready = 1'b1; #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h10)
      begin bad++; $display("FAIL bp_refill req=%b addr=%h exp=1/00000010", imem_req, imem_addr); end
    tick; dec.ready = 1'b0; #1;
    total++; if (occupancy !== 3 || imem_req !== 1'b0 || dec.pc !== 32'h4)
      begin bad++; $display("FAIL bp_after_pop occ=%0d req=%b pc=%h exp=3/0/00000004", occupancy, imem_req, dec.pc); end
    tick; #1;
    total++; if (occupancy !== 4 || imem_req !== 1'b0)
      begin bad++; $display("FAIL bp_refull occ=%0d req=%b exp=4/0", occupancy, imem_req); end
  endtask

  task automatic test_flush;
    do_reset;
    tick; tick; tick; tick; #1;
    total++; if (occupancy !== 3) begin bad++; $display("FAIL fl_pre occ=%0d exp=3", occupancy); end
    mb.jump_taken = 1'b1; mb.jump_target = 32'h100; #1;
    total++; if (pipe_flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h100)
      begin bad++; $display("FAIL fl_redirect flush=%b req=%b addr=%h exp=1/1/00000100", pipe_flush, imem_req, imem_addr); end
    tick; mb.jump_taken = 1'b0; #1;
    total++; if (occupancy !== 0 || dec.valid !== 1'b0 || imem_addr !== 32'h104)
      begin bad++; $display("FAIL fl_next occ=%0d valid=%b addr=%h exp=0/0/00000104", occupancy, dec.valid, imem_addr); end
    tick; #1;
    total++; if (dec.valid !== 1'b1 || dec.pc !== 32'h100 || dec.ins !== 32'h113 || occupancy !== 1)
      begin bad++; $display("FAIL fl_head valid=%b pc=%h ins=%h occ=%0d exp=1/00000100/00000113/1", dec.valid, dec.pc, dec.ins, occupancy); end
  endtask

  task automatic test_flush_prio;
    do_reset; dec.ready = 1'b1;
    tick; tick; tick;
    mb.jump_taken = 1'b1; mb.jump_target = 32'h40; #1;
    total++; if (pipe_flush !== 1'b1 || imem_addr !== 32'h40 || dec.pc !== 32'h4)
      begin bad++; $display("FAIL fp_jump flush=%b addr=%h pc=%h exp=1/00000040/00000004", pipe_flush, imem_addr, dec.pc); end
    tick; mb.jump_taken = 1'b0; #1;
    total++; if (occupancy !== 0 || dec.valid !== 1'b0)
      begin bad++; $display("FAIL fp_cleared occ=%0d valid=%b exp=0/0", occupancy, dec.valid); end
    tick; #1;
    total++; if (dec.valid !== 1'b1 || dec.pc !== 32'h40)
      begin bad++; $display("FAIL fp_head valid=%b pc=%h exp=1/00000040", dec.valid, dec.pc); end
    reset = 1'b1; mb.jump_taken = 1'b1; mb.jump_target = 32'h80; #1;
    total++; if (pipe_flush !== 1'b0 || imem_req !== 1'b0)
      begin bad++; $display("FAIL fp_rst_jump flush=%b req=%b exp=0/0", pipe_flush, imem_req); end
    tick; mb.jump_taken = 1'b0; reset = 1'b0; #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || occupancy !== 0 || dec.valid !== 1'b0)
      begin bad++; $display("FAIL fp_rst_resume req=%b addr=%h occ=%0d valid=%b exp=1/00000000/0/0", imem_req, imem_addr, occupancy, dec.valid); end
  endtask

  task automatic test_fault;
    do_reset; dec.ready = 1'b1;
    tick; tick;
    mb.jump_taken = 1'b1; mb.jump_target = 32'h102; #1;
    total++; if (pipe_flush !== 1'b1 || imem_req !== 1'b0)
      begin bad++; $display("FAIL ft_jump flush=%b req=%b exp=1/0", pipe_flush, imem_req); end
    tick; mb.jump_taken = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (fault !== 1'b1 || imem_req !== 1'b0 || occupancy !== 0 || dec.valid !== 1'b0)
        begin bad++; $display("FAIL ft_hold c=%0d fault=%b req=%b occ=%0d valid=%b exp=1/0/0/0", c, fault, imem_req, occupancy, dec.valid); end
      tick;
    end
    mb.jump_taken = 1'b1; mb.jump_target = 32'h200; #1;
    total++; if (pipe_flush !== 1'b1 || imem_req !== 1'b0)
      begin bad++; $display("FAIL ft_rejump flush=%b req=%b exp=1/0", pipe_flush, imem_req); end
    tick; mb.jump_taken = 1'b0; #1;
    total++; if (fault !== 1'b1 || imem_req !== 1'b0)
      begin bad++; $display("FAIL ft_sticky fault=%b req=%b exp=1/0", fault, imem_req); end
    reset = 1'b1; tick; reset = 1'b0; #1;
    total++; if (fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin bad++; $display("FAIL ft_cleared fault=%b req=%b addr=%h exp=0/1/00000000", fault, imem_req, imem_addr); end
  endtask

  task automatic test_wrap;
    logic [XLEN-1:0] exp_pc;
    int pops;
    do_reset; tick;
    mb.jump_taken = 1'b1; mb.jump_target = 32'hfffffff8; dec.ready = 1'b1; #1;
    total++; if (imem_addr !== 32'hfffffff8 || imem_req !== 1'b1)
      begin bad++; $display("FAIL wr_jump req=%b addr=%h exp=1/fffffff8", imem_req, imem_addr); end
    tick; mb.jump_taken = 1'b0;
    exp_pc = 32'hfffffff8; pops = 0;
    for (int i = 0; i < 60; i++) begin
      dec.ready = (i < 6) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      total++; if (occupancy > DEPTH) begin bad++; $display("FAIL wr_occ i=%0d occ=%0d max=%0d", i, occupancy, DEPTH); end
      if (dec.valid && dec.ready) begin
        total++; if (dec.pc !== exp_pc || dec.ins !== (exp_pc ^ 32'h13))
          begin bad++; $display("FAIL wr_pop n=%0d pc=%h ins=%h exp=%h/%h", pops, dec.pc, dec.ins, exp_pc, exp_pc ^ 32'h13); end
        exp_pc = exp_pc + 32'd4; pops++;
      end
      tick;
    end
    total++; if (pops <= 2*DEPTH) begin bad++; $display("FAIL wr_pops got=%0d exp>%0d", pops, 2*DEPTH); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_flush_prio;
    test_fault;
    test_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
